// File: rtl/usb_pkg.sv
// Shared USB definitions: handshake codes, scheduler state encoding and payload size default.
package usb_pkg;

    localparam logic [1:0] HS_ACK   = 2'd0;
    localparam logic [1:0] HS_NONE  = 2'd1;
    localparam logic [1:0] HS_NAK   = 2'd2;
    localparam logic [1:0] HS_STALL = 2'd3;

    localparam int USB_MAX_PKT = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECIDE   = 3'd1,
        ST_IN_XFER  = 3'd2,
        ST_OUT_XFER = 3'd3,
        ST_WAIT_END = 3'd4
    } sched_state_t;

endpackage

// File: rtl/usb_toggle_bank.sv
// DATA0/DATA1 toggle storage: one IN and one OUT bit per endpoint.
module usb_toggle_bank
    import usb_pkg::*;
#(
    parameter int NUM_EP = 3
) (
    input  logic       clk48mhz,
    input  logic       clear_all_i,
    input  logic       flip_en_i,
    input  logic [3:0] flip_ep_i,
    input  logic       flip_dir_in_i,
    input  logic       set_ep0_i,
    input  logic [3:0] rd_ep_i,
    input  logic       rd_dir_in_i,
    output logic       rd_toggle_o
);

    logic [NUM_EP-1:0] tog_in_q;
    logic [NUM_EP-1:0] tog_out_q;

    always_ff @(posedge clk48mhz) begin
        if (clear_all_i) begin
            tog_in_q  <= '0;
            tog_out_q <= '0;
        end else begin
            for (int i = 0; i < NUM_EP; i++) begin
                if (flip_en_i && flip_ep_i == 4'(i)) begin
                    if (flip_dir_in_i) tog_in_q[i]  <= ~tog_in_q[i];
                    else               tog_out_q[i] <= ~tog_out_q[i];
                end
            end
            // A SETUP forces both EP0 directions to DATA1, overriding any flip.
            if (set_ep0_i) begin
                tog_in_q[0]  <= 1'b1;
                tog_out_q[0] <= 1'b1;
            end
        end
    end

    // Endpoints outside the bank read as DATA0.
    always_comb begin
        rd_toggle_o = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (rd_ep_i == 4'(i)) rd_toggle_o = rd_dir_in_i ? tog_in_q[i] : tog_out_q[i];
        end
    end

endmodule

// File: rtl/usb_ep_scheduler.sv
// Endpoint scheduler: handshake decision, IN/OUT byte routing and toggle ownership.
// Optional USB_EP_SCHED_STATS_EN adds saturating nak_count/stall_count outputs.
module usb_ep_scheduler
    import usb_pkg::*;
#(
    parameter int NUM_EP  = 3,
    parameter int MAX_PKT = USB_MAX_PKT
) (
    input  logic                  clk48mhz,
    input  logic                  rst,
    input  logic                  usb_rst,
    input  logic                  transaction_active,
    input  logic                  direction_in,
    input  logic                  setup,
    input  logic                  data_strobe,
    input  logic                  success,
    input  logic [3:0]            endpoint,
    input  logic [7:0]            data_out,
    output logic [1:0]            handshake,
    output logic                  data_toggle,
    output logic [7:0]            data_in,
    output logic                  data_in_valid,
    input  logic [NUM_EP-1:0]     ep_stall,
    input  logic [NUM_EP-1:0]     ep_in_ready,
    input  logic [8*NUM_EP-1:0]   ep_in_len,
    input  logic [8*NUM_EP-1:0]   ep_in_data,
    output logic [NUM_EP-1:0]     ep_in_pop,
    output logic [NUM_EP-1:0]     ep_in_commit,
    output logic [NUM_EP-1:0]     ep_in_rewind,
    input  logic [NUM_EP-1:0]     ep_out_ready,
    output logic [7:0]            ep_out_data,
    output logic [NUM_EP-1:0]     ep_out_valid,
    output logic [NUM_EP-1:0]     ep_out_commit,
    output logic [NUM_EP-1:0]     ep_out_abort,
    output logic [NUM_EP-1:0]     ep_setup,
    output logic [3:0]            ep_sel,
    output logic                  busy
`ifdef USB_EP_SCHED_STATS_EN
    ,
    output logic [15:0]           nak_count,
    output logic [7:0]            stall_count
`endif
);

    sched_state_t      state_q;
    logic              ta_q, ds_q;
    logic [3:0]        ep_q;
    logic              dir_in_q, setup_q, success_q, overrun_q;
    logic [7:0]        count_q;
    logic [1:0]        handshake_q;
    logic [3:0]        ep_sel_q;
    logic              busy_q;
    logic [7:0]        out_data_q;
    logic [NUM_EP-1:0] in_pop_q, in_commit_q, in_rewind_q;
    logic [NUM_EP-1:0] out_valid_q, out_commit_q, out_abort_q, setup_pulse_q;

    logic              reset_req, ta_rise, ta_fall, ds_rise, pkt_ok, ep_valid;
    logic              in_ready_sel, out_ready_sel, stall_sel;
    logic [7:0]        in_len_sel, in_data_sel, len_eff;
    logic [NUM_EP-1:0] ep_onehot;
    logic [1:0]        decide_hs;
    logic              tog_flip, tog_set_ep0, end_in, end_out;

    assign reset_req = !rst || usb_rst;
    assign ta_rise   = transaction_active && !ta_q;
    assign ta_fall   = !transaction_active && ta_q;
    assign ds_rise   = data_strobe && !ds_q;
    // success on the very cycle of the falling edge still counts.
    assign pkt_ok    = success_q || success;
    assign ep_valid  = ep_q < 4'(NUM_EP);

    always_comb begin
        in_ready_sel  = 1'b0;
        out_ready_sel = 1'b0;
        stall_sel     = 1'b0;
        in_len_sel    = 8'd0;
        in_data_sel   = 8'd0;
        ep_onehot     = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (ep_q == 4'(i)) begin
                in_ready_sel  = ep_in_ready[i];
                out_ready_sel = ep_out_ready[i];
                stall_sel     = ep_stall[i];
                in_len_sel    = ep_in_len[8*i +: 8];
                in_data_sel   = ep_in_data[8*i +: 8];
                ep_onehot[i]  = 1'b1;
            end
        end
    end

    assign len_eff = (in_len_sel > 8'(MAX_PKT)) ? 8'(MAX_PKT) : in_len_sel;

    always_comb begin
        decide_hs = HS_NAK;
        if (!ep_valid || (setup_q && ep_q != 4'd0)) decide_hs = HS_STALL;
        else if (setup_q)                          decide_hs = HS_ACK;
        else if (stall_sel)                        decide_hs = HS_STALL;
        else if (dir_in_q)                         decide_hs = in_ready_sel ? HS_ACK : HS_NAK;
        else                                       decide_hs = out_ready_sel ? HS_ACK : HS_NAK;
    end

    assign end_in      = (state_q == ST_IN_XFER) && ta_fall;
    assign end_out     = (state_q == ST_OUT_XFER) && ta_fall;
    assign tog_flip    = (end_in && pkt_ok) || (end_out && pkt_ok && !overrun_q && !setup_q);
    assign tog_set_ep0 = end_out && pkt_ok && !overrun_q && setup_q;

    usb_toggle_bank #(.NUM_EP(NUM_EP)) u_toggle_bank (
        .clk48mhz      (clk48mhz),
        .clear_all_i   (reset_req),
        .flip_en_i     (tog_flip),
        .flip_ep_i     (ep_q),
        .flip_dir_in_i (end_in),
        .set_ep0_i     (tog_set_ep0),
        .rd_ep_i       (ep_sel_q),
        .rd_dir_in_i   (1'b1),
        .rd_toggle_o   (data_toggle)
    );

    always_ff @(posedge clk48mhz) begin
        if (reset_req) begin
            state_q       <= ST_IDLE;
            ta_q          <= 1'b0;
            ds_q          <= 1'b0;
            ep_q          <= 4'd0;
            dir_in_q      <= 1'b0;
            setup_q       <= 1'b0;
            success_q     <= 1'b0;
            overrun_q     <= 1'b0;
            count_q       <= 8'd0;
            handshake_q   <= HS_NAK;
            ep_sel_q      <= 4'd0;
            busy_q        <= 1'b0;
            out_data_q    <= 8'd0;
            in_pop_q      <= '0;
            in_commit_q   <= '0;
            in_rewind_q   <= '0;
            out_valid_q   <= '0;
            out_commit_q  <= '0;
            out_abort_q   <= '0;
            setup_pulse_q <= '0;
        end else begin
            ta_q          <= transaction_active;
            ds_q          <= data_strobe;
            in_pop_q      <= '0;
            in_commit_q   <= '0;
            in_rewind_q   <= '0;
            out_valid_q   <= '0;
            out_commit_q  <= '0;
            out_abort_q   <= '0;
            setup_pulse_q <= '0;
            if (state_q != ST_IDLE && success) success_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    handshake_q <= HS_NAK;
                    if (ta_rise) begin
                        ep_q      <= endpoint;
                        dir_in_q  <= direction_in;
                        setup_q   <= setup;
                        success_q <= success;
                        overrun_q <= 1'b0;
                        count_q   <= 8'd0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    handshake_q <= decide_hs;
                    ep_sel_q    <= ep_q;
                    if (ta_fall) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (decide_hs == HS_ACK) begin
                        state_q <= (dir_in_q && !setup_q) ? ST_IN_XFER : ST_OUT_XFER;
                    end else begin
                        state_q <= ST_WAIT_END;
                    end
                end
                ST_IN_XFER: begin
                    if (ta_fall) begin
                        if (pkt_ok) in_commit_q <= ep_onehot;
                        else        in_rewind_q <= ep_onehot;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (ds_rise && count_q < len_eff) begin
                        count_q  <= count_q + 8'd1;
                        in_pop_q <= ep_onehot;
                    end
                end
                ST_OUT_XFER: begin
                    if (ta_fall) begin
                        if (pkt_ok && !overrun_q) begin
                            out_commit_q <= ep_onehot;
                            if (setup_q) setup_pulse_q[0] <= 1'b1;
                        end else begin
                            out_abort_q <= ep_onehot;
                        end
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (ds_rise) begin
                        if (count_q < 8'(MAX_PKT)) begin
                            count_q     <= count_q + 8'd1;
                            out_data_q  <= data_out;
                            out_valid_q <= ep_onehot;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT_END: begin
                    if (ta_fall) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef USB_EP_SCHED_STATS_EN
    logic [15:0] nak_count_q;
    logic [7:0]  stall_count_q;

    always_ff @(posedge clk48mhz) begin
        if (reset_req) begin
            nak_count_q   <= 16'd0;
            stall_count_q <= 8'd0;
        end else if (state_q == ST_DECIDE) begin
            if (decide_hs == HS_NAK && nak_count_q != 16'hFFFF)
                nak_count_q <= nak_count_q + 16'd1;
            if (decide_hs == HS_STALL && stall_count_q != 8'hFF)
                stall_count_q <= stall_count_q + 8'd1;
        end
    end

    assign nak_count   = nak_count_q;
    assign stall_count = stall_count_q;
`endif

    assign handshake     = handshake_q;
    assign data_in       = in_data_sel;
    assign data_in_valid = (state_q == ST_IN_XFER) && (count_q < len_eff);
    assign ep_in_pop     = in_pop_q;
    assign ep_in_commit  = in_commit_q;
    assign ep_in_rewind  = in_rewind_q;
    assign ep_out_data   = out_data_q;
    assign ep_out_valid  = out_valid_q;
    assign ep_out_commit = out_commit_q;
    assign ep_out_abort  = out_abort_q;
    assign ep_setup      = setup_pulse_q;
    assign ep_sel        = ep_sel_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_usb_ep_scheduler.sv
// Directed bench for usb_ep_scheduler: handshake decisions, byte routing, pulses and toggles.
module tb_usb_ep_scheduler;

    logic        clk48mhz = 1'b0;
    logic        rst = 1'b0, usb_rst = 1'b0;
    logic        transaction_active = 1'b0, direction_in = 1'b0, setup = 1'b0;
    logic        data_strobe = 1'b0, success = 1'b0;
    logic [3:0]  endpoint = 4'd0;
    logic [7:0]  data_out = 8'd0;
    logic [1:0]  handshake;
    logic        data_toggle, data_in_valid;
    logic [7:0]  data_in, ep_out_data;
    logic [2:0]  ep_stall = 3'b000, ep_in_ready = 3'b000, ep_out_ready = 3'b000;
    logic [23:0] ep_in_len = 24'd0, ep_in_data = 24'd0;
    logic [2:0]  ep_in_pop, ep_in_commit, ep_in_rewind;
    logic [2:0]  ep_out_valid, ep_out_commit, ep_out_abort, ep_setup;
    logic [3:0]  ep_sel;
    logic        busy;
`ifdef USB_EP_SCHED_STATS_EN
    logic [15:0] nak_count;
    logic [7:0]  stall_count;
`endif

    int n_vec = 0, n_err = 0;
    int pop_c[3], cmt_c[3], rew_c[3], oval_c[3], ocmt_c[3], oab_c[3], set_c[3];

    always #10 clk48mhz = ~clk48mhz;

    usb_ep_scheduler dut (
        .clk48mhz(clk48mhz), .rst(rst), .usb_rst(usb_rst),
        .transaction_active(transaction_active), .direction_in(direction_in),
        .setup(setup), .data_strobe(data_strobe), .success(success),
        .endpoint(endpoint), .data_out(data_out),
        .handshake(handshake), .data_toggle(data_toggle), .data_in(data_in),
        .data_in_valid(data_in_valid), .ep_stall(ep_stall),
        .ep_in_ready(ep_in_ready), .ep_in_len(ep_in_len), .ep_in_data(ep_in_data),
        .ep_in_pop(ep_in_pop), .ep_in_commit(ep_in_commit), .ep_in_rewind(ep_in_rewind),
        .ep_out_ready(ep_out_ready), .ep_out_data(ep_out_data),
        .ep_out_valid(ep_out_valid), .ep_out_commit(ep_out_commit),
        .ep_out_abort(ep_out_abort), .ep_setup(ep_setup),
        .ep_sel(ep_sel), .busy(busy)
`ifdef USB_EP_SCHED_STATS_EN
        , .nak_count(nak_count), .stall_count(stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge and pulses tallied.
    task automatic tick();
        @(posedge clk48mhz);
        #1;
        for (int i = 0; i < 3; i++) begin
            pop_c[i]  += int'(ep_in_pop[i]);
            cmt_c[i]  += int'(ep_in_commit[i]);
            rew_c[i]  += int'(ep_in_rewind[i]);
            oval_c[i] += int'(ep_out_valid[i]);
            ocmt_c[i] += int'(ep_out_commit[i]);
            oab_c[i]  += int'(ep_out_abort[i]);
            set_c[i]  += int'(ep_setup[i]);
        end
    endtask

    task automatic clear_cnt();
        for (int i = 0; i < 3; i++) begin
            pop_c[i] = 0; cmt_c[i] = 0; rew_c[i] = 0; oval_c[i] = 0;
            ocmt_c[i] = 0; oab_c[i] = 0; set_c[i] = 0;
        end
    endtask

    // Leaves the bench at T+2, where handshake/ep_sel/data_toggle are valid.
    task automatic start_txn(input logic [3:0] ep, input logic din, input logic stp);
        clear_cnt();
        endpoint = ep; direction_in = din; setup = stp;
        transaction_active = 1'b1;
        tick();
        chk("busy_t1", busy, 1);
        tick();
    endtask

    task automatic strobe(input logic [7:0] d);
        data_out = d; data_strobe = 1'b1;
        tick();
        data_strobe = 1'b0;
        tick();
    endtask

    task automatic end_txn(input logic succ);
        success = succ; transaction_active = 1'b0;
        tick();
        success = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_cnt();
        tick(); tick();
        chk("rst_hs", handshake, 2);
        chk("rst_busy", busy, 0);
        chk("rst_tog", data_toggle, 0);
        chk("rst_sel", ep_sel, 0);
        chk("rst_div", data_in_valid, 0);
        chk("rst_pulses", {ep_in_pop, ep_in_commit, ep_in_rewind, ep_out_valid,
                           ep_out_commit, ep_out_abort, ep_setup}, 0);
        rst = 1'b1;
        tick();

        // SETUP to EP0, 8 bytes
        start_txn(4'd0, 1'b0, 1'b1);
        chk("setup_hs", handshake, 0);
        chk("setup_sel", ep_sel, 0);
        for (int i = 0; i < 8; i++) strobe(8'(8'h10 + i));
        end_txn(1'b1);
        chk("setup_valid", oval_c[0], 8);
        chk("setup_pulse", set_c[0], 1);
        chk("setup_commit", ocmt_c[0], 1);
        chk("setup_abort", oab_c[0], 0);
        chk("setup_lastbyte", ep_out_data, 8'h17);
        chk("setup_tog_in", data_toggle, 1);
        chk("setup_hs_idle", handshake, 2);
        chk("setup_busy_end", busy, 0);

        // IN EP1, 3 bytes, success
        ep_in_ready = 3'b010; ep_in_len[15:8] = 8'd3; ep_in_data[15:8] = 8'hA5;
        start_txn(4'd1, 1'b1, 1'b0);
        chk("in1_hs", handshake, 0);
        chk("in1_tog", data_toggle, 0);
        chk("in1_div0", data_in_valid, 1);
        chk("in1_data", data_in, 8'hA5);
        strobe(8'h00); strobe(8'h00);
        chk("in1_div2", data_in_valid, 1);
        strobe(8'h00);
        chk("in1_div3", data_in_valid, 0);
        end_txn(1'b1);
        chk("in1_pops", pop_c[1], 3);
        chk("in1_commit", cmt_c[1], 1);
        chk("in1_rewind", rew_c[1], 0);

        // IN EP1 again: toggle now 1; no success -> rewind
        start_txn(4'd1, 1'b1, 1'b0);
        chk("in1b_tog", data_toggle, 1);
        strobe(8'h00); strobe(8'h00); strobe(8'h00);
        end_txn(1'b0);
        chk("in1b_rewind", rew_c[1], 1);
        chk("in1b_commit", cmt_c[1], 0);

        ep_in_ready = 3'b000;
        start_txn(4'd1, 1'b1, 1'b0);
        chk("in1c_hs", handshake, 2);
        chk("in1c_tog", data_toggle, 1);
        end_txn(1'b0);

        // NAK / STALL decisions
        start_txn(4'd2, 1'b1, 1'b0);
        chk("in2_nak", handshake, 2);
        strobe(8'h00);
        end_txn(1'b1);
        chk("in2_nopop", pop_c[2], 0);
        chk("in2_nocommit", cmt_c[2], 0);

        ep_stall = 3'b100; ep_in_ready = 3'b100;
        start_txn(4'd2, 1'b1, 1'b0);
        chk("in2_stall", handshake, 3);
        end_txn(1'b0);

        start_txn(4'd5, 1'b1, 1'b0);
        chk("ep5_stall", handshake, 3);
        chk("ep5_sel", ep_sel, 5);
        end_txn(1'b0);

        start_txn(4'd1, 1'b0, 1'b1);
        chk("setup_ep1_stall", handshake, 3);
        end_txn(1'b1);
        chk("setup_ep1_nopulse", set_c[0] + ocmt_c[1], 0);

        ep_stall = 3'b001;
        start_txn(4'd0, 1'b0, 1'b1);
        chk("setup_ep0_stalled_ack", handshake, 0);
        end_txn(1'b1);
        chk("setup_ep0_stalled_commit", ocmt_c[0], 1);
        ep_stall = 3'b000;

        // OUT EP2, 70 bytes -> truncated at 64 and aborted
        ep_out_ready = 3'b100;
        start_txn(4'd2, 1'b0, 1'b0);
        chk("out2_hs", handshake, 0);
        for (int i = 0; i < 70; i++) strobe(8'(i));
        end_txn(1'b1);
        chk("out2_valid", oval_c[2], 64);
        chk("out2_abort", oab_c[2], 1);
        chk("out2_commit", ocmt_c[2], 0);
        chk("out2_lastbyte", ep_out_data, 63);

        // ZLP on EP2
        ep_in_len[23:16] = 8'd0;
        start_txn(4'd2, 1'b1, 1'b0);
        chk("zlp_hs", handshake, 0);
        chk("zlp_tog", data_toggle, 0);
        chk("zlp_div", data_in_valid, 0);
        end_txn(1'b1);
        chk("zlp_commit", cmt_c[2], 1);
        chk("zlp_pops", pop_c[2], 0);

        // Bus reset mid-IN on EP1 (EP1 IN toggle is 1 here)
        ep_in_ready = 3'b010;
        start_txn(4'd1, 1'b1, 1'b0);
        chk("ur_tog_before", data_toggle, 1);
        strobe(8'h00);
        clear_cnt();
        usb_rst = 1'b1; transaction_active = 1'b0;
        tick();
        chk("ur_hs", handshake, 2);
        chk("ur_busy", busy, 0);
        chk("ur_tog", data_toggle, 0);
        chk("ur_sel", ep_sel, 0);
        chk("ur_div", data_in_valid, 0);
        chk("ur_odata", ep_out_data, 0);
        usb_rst = 1'b0;
        tick(); tick();
        chk("ur_nopulse", cmt_c[1] + rew_c[1] + oab_c[1] + pop_c[1], 0);
        ep_in_ready = 3'b000;
        start_txn(4'd1, 1'b1, 1'b0);
        chk("ur_ep1_tog", data_toggle, 0);
        end_txn(1'b0);
        start_txn(4'd0, 1'b1, 1'b0);
        chk("ur_ep0_tog", data_toggle, 0);
        end_txn(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
